// File: rtl/spi_slave_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_slave_pkg : shared types and defaults for the SPI mode-3 target  |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
package spi_slave_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam logic [DEFAULT_DATA_W-1:0] DEFAULT_TX_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_slave_rtl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_slave_rtl_if : SPI pins plus RX strobe / TX handshake bundle     |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
interface spi_slave_rtl_if
  import spi_slave_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);
  logic              spi_clk_i;
  logic              spi_mosi_i;
  logic              spi_cs_i;
  logic              spi_miso_o;
  logic              spi_miso_oe_o;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_valid_o;
  logic [DATA_W-1:0] tx_data_i;
  logic              tx_valid_i;
  logic              tx_ready_o;
  logic              tx_underrun_o;
  logic              frame_abort_o;
  logic              busy_o;

  modport slave (
    input  spi_clk_i, spi_mosi_i, spi_cs_i, tx_data_i, tx_valid_i,
    output spi_miso_o, spi_miso_oe_o, rx_data_o, rx_valid_o,
           tx_ready_o, tx_underrun_o, frame_abort_o, busy_o
  );

  modport master (
    output spi_clk_i, spi_mosi_i, spi_cs_i, tx_data_i, tx_valid_i,
    input  spi_miso_o, spi_miso_oe_o, rx_data_o, rx_valid_o,
           tx_ready_o, tx_underrun_o, frame_abort_o, busy_o
  );

endinterface
`default_nettype wire

// File: rtl/spi_slave_rtl_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_sync_edge : N-flop synchronizer with preset and edge detect      |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module spi_sync_edge
  import spi_slave_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic d_i,
  output logic      q_o,
  output logic      rise_o,
  output logic      fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_slave_rtl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_slave_rtl : oversampled SPI mode-3 target, MSB first             |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module spi_slave_rtl
  import spi_slave_pkg::*;
#(
  parameter int                DATA_W      = DEFAULT_DATA_W,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] TX_DEFAULT  = DATA_W'(DEFAULT_TX_DEFAULT)
) (
  input wire logic         sys_clk,
  input wire logic         sys_rst,
  spi_slave_rtl_if.slave   bus
);

  localparam logic [1:0] ST_WAIT_IDLE = WAIT_IDLE;
  localparam logic [1:0] ST_IDLE      = IDLE;
  localparam logic [1:0] ST_ACTIVE    = ACTIVE;

  localparam int                CNT_W       = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT    = CNT_W'(DATA_W - 1);
  localparam int                SETTLE_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
    .clk(sys_clk), .rst(sys_rst), .d_i(bus.spi_clk_i),
    .q_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(sys_clk), .rst(sys_rst), .d_i(bus.spi_cs_i),
    .q_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(sys_clk), .rst(sys_rst), .d_i(bus.spi_mosi_i),
    .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  logic [1:0]          state_q,        state_d;
  logic [CNT_W-1:0]    cnt_q,          cnt_d;
  logic [SETTLE_W-1:0] settle_q,       settle_d;
  logic [DATA_W-1:0]   tx_shift_q,     tx_shift_d;
  logic [DATA_W-2:0]   rx_shift_q,     rx_shift_d;
  logic [DATA_W-1:0]   hold_q,         hold_d;
  logic                tx_ready_q,     tx_ready_d;
  logic                miso_q,         miso_d;
  logic                oe_q,           oe_d;
  logic [DATA_W-1:0]   rx_data_q,      rx_data_d;
  logic                rx_valid_q,     rx_valid_d;
  logic                underrun_pend_q, underrun_pend_d;
  logic                underrun_q,     underrun_d;
  logic                abort_q,        abort_d;
  logic                load;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    tx_shift_d      = tx_shift_q;
    rx_shift_d      = rx_shift_q;
    hold_d          = hold_q;
    tx_ready_d      = tx_ready_q;
    miso_d          = miso_q;
    oe_d            = oe_q;
    rx_data_d       = rx_data_q;
    rx_valid_d      = 1'b0;
    underrun_pend_d = underrun_pend_q;
    underrun_d      = 1'b0;
    abort_d         = 1'b0;
    load            = 1'b0;
    // Synchronizer presets read as "CS high" until real samples have flushed through.
    settle_d        = (settle_q == SETTLE_DONE) ? settle_q : settle_q + 1'b1;

    case (state_q)
      ST_WAIT_IDLE: begin
        if ((settle_q == SETTLE_DONE) && cs_s) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
          oe_d    = 1'b1;
          load    = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          state_d         = ST_IDLE;
          oe_d            = 1'b0;
          miso_d          = 1'b1;
          abort_d         = (cnt_q != '0);
          cnt_d           = '0;
          rx_shift_d      = '0;
          underrun_pend_d = 1'b0;
        end else if (sclk_fall) begin
          // Underrun is flagged only once a default word actually starts shifting out.
          miso_d          = tx_shift_q[DATA_W-1];
          tx_shift_d      = tx_shift_q << 1;
          underrun_d      = underrun_pend_q;
          underrun_pend_d = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_W-3:0], mosi_s};
          if (cnt_q == LAST_BIT) begin
            rx_data_d  = {rx_shift_q, mosi_s};
            rx_valid_d = 1'b1;
            cnt_d      = '0;
            load       = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_WAIT_IDLE;
    endcase

    if (load) begin
      if (!tx_ready_q) begin
        tx_shift_d      = hold_q;
        tx_ready_d      = 1'b1;
        underrun_pend_d = 1'b0;
      end else if (bus.tx_valid_i) begin
        tx_shift_d      = bus.tx_data_i;
        underrun_pend_d = 1'b0;
      end else begin
        tx_shift_d      = TX_DEFAULT;
        underrun_pend_d = 1'b1;
      end
    end else if (bus.tx_valid_i && tx_ready_q) begin
      hold_d     = bus.tx_data_i;
      tx_ready_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q         <= ST_WAIT_IDLE;
      cnt_q           <= '0;
      settle_q        <= '0;
      tx_shift_q      <= '0;
      rx_shift_q      <= '0;
      hold_q          <= '0;
      tx_ready_q      <= 1'b1;
      miso_q          <= 1'b1;
      oe_q            <= 1'b0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      underrun_pend_q <= 1'b0;
      underrun_q      <= 1'b0;
      abort_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      settle_q        <= settle_d;
      tx_shift_q      <= tx_shift_d;
      rx_shift_q      <= rx_shift_d;
      hold_q          <= hold_d;
      tx_ready_q      <= tx_ready_d;
      miso_q          <= miso_d;
      oe_q            <= oe_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      underrun_pend_q <= underrun_pend_d;
      underrun_q      <= underrun_d;
      abort_q         <= abort_d;
    end
  end

  assign bus.spi_miso_o    = miso_q;
  assign bus.spi_miso_oe_o = oe_q;
  assign bus.rx_data_o     = rx_data_q;
  assign bus.rx_valid_o    = rx_valid_q;
  assign bus.tx_ready_o    = tx_ready_q;
  assign bus.tx_underrun_o = underrun_q;
  assign bus.frame_abort_o = abort_q;
  assign bus.busy_o        = (state_q == ST_ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_rtl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spi_slave_rtl : directed + random frames against a queue model    |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
module tb_spi_slave_rtl;
  import spi_slave_pkg::*;

  localparam int DATA_W = 8;
  localparam int SYNC   = 2;
  localparam int HALF   = 4;
  localparam logic [7:0] TXD = 8'hFF;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  spi_slave_rtl_if #(.DATA_W(DATA_W)) bus ();

  spi_slave_rtl #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC), .TX_DEFAULT(TXD)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Output monitor: only this process writes these.
  logic [7:0] rx_obs[$];
  int underrun_seen = 0, abort_seen = 0, ready_low_seen = 0;
  always @(negedge sys_clk) begin
    if (bus.rx_valid_o === 1'b1) rx_obs.push_back(bus.rx_data_o);
    if (bus.tx_underrun_o === 1'b1) underrun_seen++;
    if (bus.frame_abort_o === 1'b1) abort_seen++;
    if (bus.tx_ready_o !== 1'b1) ready_low_seen++;
  end

  // Reference: accepted TX words queue in order; each load takes the oldest or the default.
  logic [7:0] model_q[$];
  logic [7:0] mo_words[4];
  logic [7:0] mi_words[4];
  logic [7:0] exp_words[4];
  bit         exp_dflt[4];
  int         inj_ready_base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic model_load(output logic [7:0] w, output bit dflt);
    if (model_q.size() > 0) begin
      w = model_q.pop_front();
      dflt = 1'b0;
    end else begin
      w = TXD;
      dflt = 1'b1;
    end
  endtask

  task automatic tx_write(input logic [7:0] d);
    int k = 0;
    bus.tx_data_i  = d;
    bus.tx_valid_i = 1'b1;
    while (bus.tx_ready_o !== 1'b1 && k < 2000) begin
      tick(1);
      k++;
    end
    chk("tx_accept_timeout", 32'(k >= 2000), 32'd0);
    tick(1);
    model_q.push_back(d);
    bus.tx_valid_i = 1'b0;
  endtask

  // Master side: drive MOSI on fall, sample MISO just before each rise.
  task automatic xfer_bits(input logic [7:0] mo, input int nb, input bit inj,
                           input logic [7:0] injd, output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nb; i++) begin
      bus.spi_clk_i  = 1'b0;
      bus.spi_mosi_i = mo[7-i];
      tick(HALF);
      mi = {mi[6:0], bus.spi_miso_o};
      bus.spi_clk_i = 1'b1;
      if (inj && i == nb - 1) begin
        tick(SYNC);
        bus.tx_data_i  = injd;
        bus.tx_valid_i = 1'b1;
        model_q.push_back(injd);
        inj_ready_base = ready_low_seen;
        tick(1);
        bus.tx_valid_i = 1'b0;
        tick(HALF - SYNC - 1);
      end else begin
        tick(HALF);
      end
    end
  endtask

  task automatic run_frame(input int n, input int inj_word, input logic [7:0] inj_data);
    logic [7:0] mi;
    bus.spi_cs_i = 1'b0;
    model_load(exp_words[0], exp_dflt[0]);
    tick(HALF);
    for (int w = 0; w < n; w++) begin
      xfer_bits(mo_words[w], 8, (w == inj_word), inj_data, mi);
      mi_words[w] = mi;
      model_load(exp_words[w+1], exp_dflt[w+1]);
    end
    tick(HALF);
    bus.spi_cs_i = 1'b1;
    tick(HALF * 2);
  endtask

  task automatic check_frame(input string tag, input int n, input int rx_base,
                             input int ur_base, input int ab_base);
    int exp_ur = 0;
    chk({tag, "_rx_count"}, 32'(rx_obs.size() - rx_base), 32'(n));
    for (int w = 0; w < n; w++) begin
      if (rx_base + w < rx_obs.size())
        chk({tag, "_rx_data"}, 32'(rx_obs[rx_base+w]), 32'(mo_words[w]));
      chk({tag, "_miso_word"}, 32'(mi_words[w]), 32'(exp_words[w]));
      if (exp_dflt[w]) exp_ur++;
    end
    chk({tag, "_underruns"}, 32'(underrun_seen - ur_base), 32'(exp_ur));
    chk({tag, "_aborts"}, 32'(abort_seen - ab_base), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int rb, ub, ab, n;
    logic [7:0] mi;
    bus.spi_clk_i  = 1'b1;
    bus.spi_mosi_i = 1'b0;
    bus.spi_cs_i   = 1'b1;
    bus.tx_data_i  = '0;
    bus.tx_valid_i = 1'b0;
    sys_rst = 1'b1;
    tick(3);
    chk("rst_miso",     32'(bus.spi_miso_o),    32'd1);
    chk("rst_oe",       32'(bus.spi_miso_oe_o), 32'd0);
    chk("rst_rx_data",  32'(bus.rx_data_o),     32'd0);
    chk("rst_rx_valid", 32'(bus.rx_valid_o),    32'd0);
    chk("rst_underrun", 32'(bus.tx_underrun_o), 32'd0);
    chk("rst_abort",    32'(bus.frame_abort_o), 32'd0);
    chk("rst_busy",     32'(bus.busy_o),        32'd0);
    chk("rst_tx_ready", 32'(bus.tx_ready_o),    32'd1);
    sys_rst = 1'b0;
    tick(SYNC + 4);

    // 1: preloaded A5, master sends 3C
    tx_write(8'hA5);
    mo_words[0] = 8'h3C;
    rb = rx_obs.size(); ub = underrun_seen; ab = abort_seen;
    run_frame(1, -1, 8'h00);
    check_frame("t1", 1, rb, ub, ab);

    // 2: two words, only 11 preloaded
    tx_write(8'h11);
    mo_words[0] = 8'hC3; mo_words[1] = 8'h5A;
    rb = rx_obs.size(); ub = underrun_seen; ab = abort_seen;
    run_frame(2, -1, 8'h00);
    check_frame("t2", 2, rb, ub, ab);

    // 3: bypass write in the exact completion cycle
    tx_write(8'h5E);
    mo_words[0] = 8'($urandom); mo_words[1] = 8'($urandom);
    rb = rx_obs.size(); ub = underrun_seen; ab = abort_seen;
    run_frame(2, 0, 8'h77);
    check_frame("t3", 2, rb, ub, ab);
    chk("t3_ready_stays_high", 32'(ready_low_seen - inj_ready_base), 32'd0);

    // 4: abort after 5 bits, then a clean frame
    rb = rx_obs.size(); ab = abort_seen;
    bus.spi_cs_i = 1'b0;
    model_load(exp_words[0], exp_dflt[0]);
    tick(HALF);
    xfer_bits(8'hF0, 5, 1'b0, 8'h00, mi);
    tick(HALF);
    bus.spi_cs_i = 1'b1;
    tick(HALF * 2);
    chk("t4_abort_pulse", 32'(abort_seen - ab), 32'd1);
    chk("t4_no_rx",       32'(rx_obs.size() - rb), 32'd0);
    mo_words[0] = 8'h0F;
    rb = rx_obs.size(); ub = underrun_seen; ab = abort_seen;
    run_frame(1, -1, 8'h00);
    check_frame("t4", 1, rb, ub, ab);

    // 5: reset mid-frame with CS held low
    rb = rx_obs.size();
    bus.spi_cs_i = 1'b0;
    model_load(exp_words[0], exp_dflt[0]);
    tick(HALF);
    xfer_bits(8'hE7, 3, 1'b0, 8'h00, mi);
    sys_rst = 1'b1;
    tick(1);
    sys_rst = 1'b0;
    model_q.delete();
    chk("t5_rst_miso",     32'(bus.spi_miso_o),    32'd1);
    chk("t5_rst_oe",       32'(bus.spi_miso_oe_o), 32'd0);
    chk("t5_rst_rx_data",  32'(bus.rx_data_o),     32'd0);
    chk("t5_rst_busy",     32'(bus.busy_o),        32'd0);
    chk("t5_rst_tx_ready", 32'(bus.tx_ready_o),    32'd1);
    xfer_bits(8'hE7 << 3, 5, 1'b0, 8'h00, mi);
    tick(HALF);
    chk("t5_silent_oe",   32'(bus.spi_miso_oe_o), 32'd0);
    chk("t5_silent_busy", 32'(bus.busy_o),        32'd0);
    chk("t5_no_rx",       32'(rx_obs.size() - rb), 32'd0);
    bus.spi_cs_i = 1'b1;
    tick(HALF * 2);
    mo_words[0] = 8'h81;
    rb = rx_obs.size(); ub = underrun_seen; ab = abort_seen;
    run_frame(1, -1, 8'h00);
    check_frame("t5", 1, rb, ub, ab);

    // 6: back-to-back writes, second stalls until the CS-fall load
    mo_words[0] = 8'($urandom); mo_words[1] = 8'($urandom);
    rb = rx_obs.size(); ub = underrun_seen; ab = abort_seen;
    fork
      begin
        tx_write(8'h01);
        chk("t6_ready_low_after_write", 32'(bus.tx_ready_o), 32'd0);
        tx_write(8'h02);
      end
      begin
        tick(3);
        run_frame(2, -1, 8'h00);
      end
    join
    check_frame("t6", 2, rb, ub, ab);
    chk("t6_first_word",  32'(mi_words[0]), 32'h01);
    chk("t6_second_word", 32'(mi_words[1]), 32'h02);

    // Random frames
    for (int it = 0; it < 6; it++) begin
      n = int'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
      for (int w = 0; w < n; w++) mo_words[w] = 8'($urandom);
      rb = rx_obs.size(); ub = underrun_seen; ab = abort_seen;
      run_frame(n, -1, 8'h00);
      check_frame("rnd", n, rb, ub, ab);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
